exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage of the 5-stage pipelined RV32 core.
- Holds the ID/EX pipeline register and operand forwarding muxes.
- Contains the ALU, branch/jump resolution and an iterative RV32M multiply/divide unit.
- Its E-suffixed outputs feed the Memory stage's EX/MEM register directly. It raises BusyE so the hazard unit can stall while a MUL/DIV is in flight.

Parameters:
- WIDTH, 32, datapath width. The iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- StallE  in  1  hold ID/EX register (from hazard unit)
- FlushE  in  1  load bubble into ID/EX; abort any MUL/DIV
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MulDivD  in  1 each  decode controls
- ResultSrcD  in  2  result select
- ALUControlD  in  4  ALU op (package enum)
- MulDivOpD  in  3  RV32M funct3
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  WIDTH each  decode data
- Rs1D, Rs2D, RdD  in  5 each  register indices
- ForwardAE, ForwardBE  in  2 each  00 = regfile, 01 = ResultW, 10 = ALUResultM
- ResultW, ALUResultM  in  WIDTH each  forwarding sources
- RegWriteE, MemWriteE  out  1 each  to Memory stage
- ResultSrcE  out  2  to Memory stage
- ALUResultE, WriteDataE, PCPlus4E, PCTargetE  out  WIDTH each
- RdE, Rs1E, Rs2E  out  5 each  (Rs1E/Rs2E go to the hazard unit)
- PCSrcE  out  1  redirect fetch
- BusyE  out  1  MUL/DIV in progress; stall F/D/E

Behaviour:
ID/EX register
- Reset (async, rst_n = 0): all ID/EX fields are 0, so every control output and every data output is 0. MUL/DIV FSM goes to IDLE.
- Each clk edge, priority is: FlushE (load bubble: all fields 0) > StallE or BusyE (hold) > load D inputs.

Operands and ALU
- SrcAE = ForwardAE mux. WriteDataE = ForwardBE mux. SrcBE = ALUSrcE ? ImmExtE : WriteDataE. Encoding 11 behaves as 00.
- ALU ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB.
- Shift amount is SrcBE[4:0].
- Arithmetic is modulo 2^WIDTH.

Branch and jump
- ZeroE = (SrcAE == SrcBE_reg), where SrcBE_reg is the ForwardBE mux output, not the immediate.
- PCTargetE = PCE + ImmExtE.
- PCSrcE = JumpE | (BranchE & ZeroE).

MUL/DIV FSM (states IDLE, BUSY, DONE)
- Active only when MulDivE = 1.
- IDLE, MulDivE = 1:
  - BusyE = 1.
  - Capture forwarded operands and take absolute values per signedness.
  - Counter = 0; go to BUSY.
- BUSY:
  - BusyE = 1.
  - One shift-add (multiply) or one restoring-subtract (divide) step per cycle.
  - After WIDTH steps, go to DONE.
- DONE:
  - BusyE = 0.
  - Apply sign fix-up; ALUResultE = selected result.
  - Go to IDLE on the next edge; the register advances at that edge.
- Latency: a MUL/DIV occupies E for WIDTH + 2 cycles (34 at WIDTH = 32).
- Operands are latched at the IDLE cycle; later changes on the forwarding inputs are ignored.
- While BusyE = 1, RegWriteE = MemWriteE = 0, so M receives bubbles. PCSrcE = 0.
- Op results:
  - MUL: low word.
  - MULH, MULHSU, MULHU: high word.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Divide-by-zero: quotient = all ones; remainder = dividend.
- Signed overflow (DIV of 0x80000000 by -1): quotient = 0x80000000; remainder = 0.
- These special cases still take the full latency.
- Remainder takes the sign of the dividend.
- FlushE while in BUSY or DONE: FSM goes to IDLE at that edge. BusyE = 0 the following cycle; no result is written.
- rst_n asserted mid-operation: FSM goes to IDLE immediately (asynchronous); BusyE = 0.
- Back-to-back MUL/DIV: the second one enters IDLE on the edge after DONE and starts fresh.

Decomposition:
- Package riscv_pkg holds:
  - alu_op_t enum: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, SLT = 5, SLTU = 6, SLL = 7, SRL = 8, SRA = 9, PASSB = 10.
  - muldiv_op_t enum using RV32M funct3 (MUL = 0 … REMU = 7).
  - Forward-select constants.
  - muldiv_state_t enum.
- Sub-module muldiv_unit contains the FSM, counter, and iterative multiply/divide datapath. Its interface: start, op, a, b, flush, busy, done, result.

Test Plan:
1. ALUSrcD = 1, ImmExtD = 3, RD1D = 5, ForwardAE = 10, ALUResultM = 7, ADD -> next cycle ALUResultE = 10, RegWriteE passes through.
2. BranchD = 1, RD1D = RD2D = 0x55, PCD = 0x100, ImmExtD = 0x20 -> PCSrcE = 1, PCTargetE = 0x120. With RD2D = 0x56 -> PCSrcE = 0.
3. DIVU 100 / 7 -> BusyE = 1 for 33 cycles, RegWriteE = 0 throughout. Cycle 34: ALUResultE = 14, BusyE = 0. REMU -> 2.
4. DIV 5 / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -7 % 2 -> 0xFFFFFFFF.
5. MUL 0xFFFFFFFF * 2 -> 0xFFFFFFFE; MULH -3 * 5 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
6. FlushE at BUSY cycle 10 -> BusyE = 0 and RegWriteE = 0 next cycle, then a following MUL completes in 34 cycles. rst_n low mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32 execute stage: ALU opcodes, RV32M funct3 codes,
// forwarding selects and the MUL/DIV sequencer states.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUM    = 2'b10;

  // MUL is taken as unsigned: its low word does not depend on signedness.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/exec_stage_muldiv.sv
// Iterative RV32M unit: unsigned shift-add multiply / restoring divide on
// operand magnitudes, one step per cycle, with a sign fix-up on the way out.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    r_state, w_nextState;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi, r_lo, r_div;
  logic [2:0]       r_op;
  logic             r_negA, r_negRes, r_bZero;

  logic             w_negA, w_negB, w_geq;
  logic [WIDTH-1:0] w_absA, w_absB, w_rem, w_quot, w_remFix;
  logic [WIDTH:0]   w_sum, w_shift;
  logic [2*WIDTH-1:0] w_prod;

  assign w_negA = op_signed_a(op) & a[WIDTH-1];
  assign w_negB = op_signed_b(op) & b[WIDTH-1];
  assign w_absA = w_negA ? -a : a;
  assign w_absB = w_negB ? -b : b;

  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_div : '0)};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_geq   = w_shift >= {1'b0, r_div};
  assign w_rem   = w_shift[WIDTH-1:0] - r_div;

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = start;
        if (start && !flush) w_nextState = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (flush)                            w_nextState = IDLE;
        else if (r_count == CW'(WIDTH - 1))   w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Divide shifts the quotient into r_lo and keeps the partial remainder in
  // r_hi; multiply shifts the product right through {r_hi, r_lo}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_div    <= '0;
      r_op     <= '0;
      r_negA   <= 1'b0;
      r_negRes <= 1'b0;
      r_bZero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start && !flush) begin
          r_op     <= op;
          r_negA   <= w_negA;
          r_negRes <= w_negA ^ w_negB;
          r_bZero  <= (b == '0);
          r_hi     <= '0;
          r_lo     <= w_absA;
          r_div    <= w_absB;
          r_count  <= '0;
        end
        BUSY: if (!flush) begin
          r_count <= r_count + CW'(1);
          if (r_op[2]) begin
            r_hi <= w_geq ? w_rem : w_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_geq};
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Signed overflow falls out naturally: |0x80000000| / 1 negated is itself.
  assign w_prod   = r_negRes ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quot   = r_bZero ? '1 : (r_negRes ? -r_lo : r_lo);
  assign w_remFix = r_negA ? -r_hi : r_hi;

  always_comb begin
    case (r_op)
      MD_MUL:                       result = w_prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              result = w_quot;
      default:                      result = w_remFix;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage of the 5-stage RV32 pipeline: ID/EX register, forwarding,
// ALU, branch resolution and the iterative RV32M unit.
module exec_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             MulDivD,
  input  logic [1:0]       ResultSrcD,
  input  logic [3:0]       ALUControlD,
  input  logic [2:0]       MulDivOpD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [WIDTH-1:0] PCD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUResultM,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCPlus4E,
  output logic [WIDTH-1:0] PCTargetE,
  output logic [4:0]       RdE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic             PCSrcE,
  output logic             BusyE
);

  logic             r_RegWrite, r_MemWrite, r_Jump, r_Branch, r_ALUSrc, r_MulDiv;
  logic [1:0]       r_ResultSrc;
  logic [3:0]       r_ALUControl;
  logic [2:0]       r_MulDivOp;
  logic [WIDTH-1:0] r_RD1, r_RD2, r_ImmExt, r_PC, r_PCPlus4;
  logic [4:0]       r_Rs1, r_Rs2, r_Rd;

  logic             w_busy, w_mdDone, w_zero;
  logic [WIDTH-1:0] w_srcA, w_writeData, w_srcB, w_aluResult, w_mdResult;
  logic [4:0]       w_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_RegWrite <= 1'b0; r_MemWrite <= 1'b0; r_Jump <= 1'b0;
      r_Branch <= 1'b0; r_ALUSrc <= 1'b0; r_MulDiv <= 1'b0;
      r_ResultSrc <= '0; r_ALUControl <= '0; r_MulDivOp <= '0;
      r_RD1 <= '0; r_RD2 <= '0; r_ImmExt <= '0; r_PC <= '0; r_PCPlus4 <= '0;
      r_Rs1 <= '0; r_Rs2 <= '0; r_Rd <= '0;
    end else if (FlushE) begin
      r_RegWrite <= 1'b0; r_MemWrite <= 1'b0; r_Jump <= 1'b0;
      r_Branch <= 1'b0; r_ALUSrc <= 1'b0; r_MulDiv <= 1'b0;
      r_ResultSrc <= '0; r_ALUControl <= '0; r_MulDivOp <= '0;
      r_RD1 <= '0; r_RD2 <= '0; r_ImmExt <= '0; r_PC <= '0; r_PCPlus4 <= '0;
      r_Rs1 <= '0; r_Rs2 <= '0; r_Rd <= '0;
    end else if (!StallE && !w_busy) begin
      r_RegWrite <= RegWriteD; r_MemWrite <= MemWriteD; r_Jump <= JumpD;
      r_Branch <= BranchD; r_ALUSrc <= ALUSrcD; r_MulDiv <= MulDivD;
      r_ResultSrc <= ResultSrcD; r_ALUControl <= ALUControlD; r_MulDivOp <= MulDivOpD;
      r_RD1 <= RD1D; r_RD2 <= RD2D; r_ImmExt <= ImmExtD; r_PC <= PCD; r_PCPlus4 <= PCPlus4D;
      r_Rs1 <= Rs1D; r_Rs2 <= Rs2D; r_Rd <= RdD;
    end
  end

  always_comb begin
    case (ForwardAE)
      FWD_RESULTW: w_srcA = ResultW;
      FWD_ALUM:    w_srcA = ALUResultM;
      default:     w_srcA = r_RD1;
    endcase
    case (ForwardBE)
      FWD_RESULTW: w_writeData = ResultW;
      FWD_ALUM:    w_writeData = ALUResultM;
      default:     w_writeData = r_RD2;
    endcase
  end

  assign w_srcB  = r_ALUSrc ? r_ImmExt : w_writeData;
  assign w_shamt = w_srcB[4:0];

  always_comb begin
    case (alu_op_t'(r_ALUControl))
      ALU_ADD:   w_aluResult = w_srcA + w_srcB;
      ALU_SUB:   w_aluResult = w_srcA - w_srcB;
      ALU_AND:   w_aluResult = w_srcA & w_srcB;
      ALU_OR:    w_aluResult = w_srcA | w_srcB;
      ALU_XOR:   w_aluResult = w_srcA ^ w_srcB;
      ALU_SLT:   w_aluResult = {{(WIDTH-1){1'b0}}, $signed(w_srcA) < $signed(w_srcB)};
      ALU_SLTU:  w_aluResult = {{(WIDTH-1){1'b0}}, w_srcA < w_srcB};
      ALU_SLL:   w_aluResult = w_srcA << w_shamt;
      ALU_SRL:   w_aluResult = w_srcA >> w_shamt;
      ALU_SRA:   w_aluResult = $unsigned($signed(w_srcA) >>> w_shamt);
      ALU_PASSB: w_aluResult = w_srcB;
      default:   w_aluResult = '0;
    endcase
  end

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (r_MulDiv),
    .op     (r_MulDivOp),
    .a      (w_srcA),
    .b      (w_writeData),
    .flush  (FlushE),
    .busy   (w_busy),
    .done   (w_mdDone),
    .result (w_mdResult)
  );

  // Branches compare the two register operands, never the immediate.
  assign w_zero = (w_srcA == w_writeData);

  assign RegWriteE  = r_RegWrite & ~w_busy;
  assign MemWriteE  = r_MemWrite & ~w_busy;
  assign ResultSrcE = r_ResultSrc;
  assign ALUResultE = w_mdDone ? w_mdResult : w_aluResult;
  assign WriteDataE = w_writeData;
  assign PCPlus4E   = r_PCPlus4;
  assign PCTargetE  = r_PC + r_ImmExt;
  assign RdE        = r_Rd;
  assign Rs1E       = r_Rs1;
  assign Rs2E       = r_Rs2;
  assign PCSrcE     = ~w_busy & (r_Jump | (r_Branch & w_zero));
  assign BusyE      = w_busy;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed cases plus randomized ALU and
// RV32M traffic checked against a plain-arithmetic reference model.
module tb_exec_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MulDivD;
  logic [1:0]  ResultSrcD;
  logic [3:0]  ALUControlD;
  logic [2:0]  MulDivOpD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUResultM;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic        PCSrcE, BusyE;
  logic [148:0] allOut;

  int vectors = 0;
  int miscompares = 0;

  exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .MulDivD(MulDivD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .MulDivOpD(MulDivOpD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ALUResultM(ALUResultM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .PCTargetE(PCTargetE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .PCSrcE(PCSrcE), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  assign allOut = {RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, PCPlus4E,
                   PCTargetE, RdE, Rs1E, Rs2E, PCSrcE, BusyE};

  function automatic logic [31:0] fwd_model(input logic [1:0] sel,
                                            input logic [31:0] rf, rw, am);
    case (sel)
      2'b01:   return rw;
      2'b10:   return am;
      default: return rf;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b);
    int sa, sb, sh;
    sa = int'(a);
    sb = int'(b);
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return 32'(sa >>> sh);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] muldiv_model(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'(int'(a));
    sb  = longint'(int'(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(int'(a) / int'(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic clear_d();
    StallE = 0; FlushE = 0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0; MulDivD = 0;
    ResultSrcD = 0; ALUControlD = 0; MulDivOpD = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0; ALUResultM = 0;
  endtask

  task automatic issue_muldiv(input logic [2:0] op, input logic [31:0] a, b);
    clear_d();
    MulDivD = 1; MulDivOpD = op; RD1D = a; RD2D = b; RegWriteD = 1; RdD = 5'd9;
  endtask

  // Returns once BusyE drops (the DONE cycle) or after a bounded wait.
  task automatic do_muldiv(input logic [2:0] op, input logic [31:0] a, b, input bit scramble,
                           output int busyCycles, output logic [31:0] res,
                           output bit sawWrite, output logic doneWrite);
    issue_muldiv(op, a, b);
    @(posedge clk); #1;
    clear_d();
    busyCycles = 0;
    sawWrite   = 0;
    while (BusyE === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      if (RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || PCSrcE !== 1'b0) sawWrite = 1;
      if (scramble && busyCycles == 2) begin
        ForwardAE = 2'b01; ForwardBE = 2'b10;
        ResultW = $urandom; ALUResultM = $urandom;
      end
      @(posedge clk); #1;
    end
    res       = ALUResultE;
    doneWrite = RegWriteE;
    ForwardAE = 0; ForwardBE = 0;
  endtask

  task automatic test_reset();
    clear_d();
    rst_n = 0;
    RegWriteD = 1; MemWriteD = 1; RD1D = 32'hDEAD_BEEF; PCD = 32'h40; ImmExtD = 32'h8; RdD = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (allOut !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
    end
    clear_d();
    rst_n = 1;
  endtask

  task automatic test_alu_forward();
    clear_d();
    ALUSrcD = 1; ImmExtD = 32'd3; RD1D = 32'd5; ForwardAE = 2'b10; ALUResultM = 32'd7;
    ALUControlD = ALU_ADD; RegWriteD = 1; RdD = 5'd4;
    @(posedge clk); #1;
    vectors++;
    if (ALUResultE !== 32'd10) begin
      miscompares++;
      $display("[TB] FAIL alu_fwd_add: got %0d expected 10", ALUResultE);
    end
    vectors++;
    if (RegWriteE !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL alu_fwd_regwrite: got %b expected 1", RegWriteE);
    end
  endtask

  task automatic test_branch();
    clear_d();
    BranchD = 1; RD1D = 32'h55; RD2D = 32'h55; PCD = 32'h100; ImmExtD = 32'h20;
    ALUControlD = ALU_SUB;
    @(posedge clk); #1;
    vectors++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      miscompares++;
      $display("[TB] FAIL branch_taken: got pcsrc=%b target=%h expected 1/120", PCSrcE, PCTargetE);
    end
    RD2D = 32'h56;
    @(posedge clk); #1;
    vectors++;
    if (PCSrcE !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL branch_not_taken: got %b expected 0", PCSrcE);
    end
  endtask

  task automatic test_stall_flush();
    clear_d();
    RD1D = 32'd1; RD2D = 32'd2; ALUControlD = ALU_ADD; RegWriteD = 1; RdD = 5'd7;
    @(posedge clk); #1;
    RD1D = 32'd100; RdD = 5'd8; StallE = 1;
    @(posedge clk); #1;
    vectors++;
    if (ALUResultE !== 32'd3 || RdE !== 5'd7) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got %0d rd=%0d expected 3 rd=7", ALUResultE, RdE);
    end
    FlushE = 1;
    @(posedge clk); #1;
    vectors++;
    if (ALUResultE !== 32'd0 || RegWriteE !== 1'b0 || RdE !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_bubble: got %h rw=%b rd=%0d expected 0", ALUResultE, RegWriteE, RdE);
    end
    clear_d();
  endtask

  task automatic test_random_alu();
    logic [31:0] srcA, wd, srcB, expAlu;
    logic expPcSrc;
    for (int i = 0; i < 40; i++) begin
      clear_d();
      ALUControlD = 4'($urandom_range(0, 10));
      RD1D = $urandom; RD2D = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
      ImmExtD = $urandom; ALUSrcD = 1'($urandom_range(0, 1));
      ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
      ResultW = $urandom; ALUResultM = $urandom;
      BranchD = 1'($urandom_range(0, 1)); JumpD = ($urandom_range(0, 3) == 0);
      PCD = $urandom; PCPlus4D = PCD + 32'd4;
      RegWriteD = 1'($urandom_range(0, 1)); RdD = 5'($urandom);
      @(posedge clk); #1;
      srcA     = fwd_model(ForwardAE, RD1D, ResultW, ALUResultM);
      wd       = fwd_model(ForwardBE, RD2D, ResultW, ALUResultM);
      srcB     = ALUSrcD ? ImmExtD : wd;
      expAlu   = alu_model(ALUControlD, srcA, srcB);
      expPcSrc = JumpD | (BranchD & (srcA == wd));
      vectors++;
      if (ALUResultE !== expAlu) begin
        miscompares++;
        $display("[TB] FAIL rand_alu op=%0d: got %h expected %h", ALUControlD, ALUResultE, expAlu);
      end
      vectors++;
      if (WriteDataE !== wd || PCTargetE !== PCD + ImmExtD || PCPlus4E !== PCPlus4D) begin
        miscompares++;
        $display("[TB] FAIL rand_data: got wd=%h tgt=%h p4=%h expected %h %h %h",
                 WriteDataE, PCTargetE, PCPlus4E, wd, PCD + ImmExtD, PCPlus4D);
      end
      vectors++;
      if (PCSrcE !== expPcSrc || RegWriteE !== RegWriteD || RdE !== RdD) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl: got pcsrc=%b rw=%b rd=%0d expected %b %b %0d",
                 PCSrcE, RegWriteE, RdE, expPcSrc, RegWriteD, RdD);
      end
    end
    clear_d();
  endtask

  task automatic test_divu();
    int cyc; logic [31:0] res; bit sawW; logic rwDone;
    do_muldiv(MD_DIVU, 32'd100, 32'd7, 0, cyc, res, sawW, rwDone);
    vectors++;
    if (cyc != 33 || sawW || res !== 32'd14 || rwDone !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL divu: got busy=%0d bubbleleak=%0d res=%0d rw=%b expected 33/0/14/1",
               cyc, sawW, res, rwDone);
    end
    do_muldiv(MD_REMU, 32'd100, 32'd7, 0, cyc, res, sawW, rwDone);
    vectors++;
    if (cyc != 33 || res !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL remu: got busy=%0d res=%0d expected 33/2", cyc, res);
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [4] = '{MD_DIV, MD_REM, MD_DIV, MD_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    int cyc; logic [31:0] res; bit sawW; logic rwDone;
    for (int i = 0; i < 4; i++) begin
      do_muldiv(ops[i], as[i], bs[i], 0, cyc, res, sawW, rwDone);
      vectors++;
      if (cyc != 33 || res !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL div_special%0d: got busy=%0d res=%h expected 33/%h", i, cyc, res, exp[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [3] = '{MD_MUL, MD_MULH, MD_MULHU};
    logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'd2, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int cyc; logic [31:0] res; bit sawW; logic rwDone;
    for (int i = 0; i < 3; i++) begin
      do_muldiv(ops[i], as[i], bs[i], 0, cyc, res, sawW, rwDone);
      vectors++;
      if (cyc != 33 || res !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL mul%0d: got busy=%0d res=%h expected 33/%h", i, cyc, res, exp[i]);
      end
    end
  endtask

  task automatic test_flush_muldiv();
    int cyc; logic [31:0] res; bit sawW; logic rwDone;
    issue_muldiv(MD_DIVU, 32'd1000, 32'd3);
    @(posedge clk); #1;
    clear_d();
    repeat (10) begin @(posedge clk); #1; end
    vectors++;
    if (BusyE !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_pre_busy: got %b expected 1", BusyE);
    end
    FlushE = 1;
    @(posedge clk); #1;
    FlushE = 0;
    vectors++;
    if (BusyE !== 1'b0 || RegWriteE !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_abort: got busy=%b rw=%b expected 0/0", BusyE, RegWriteE);
    end
    do_muldiv(MD_MUL, 32'h1234, 32'h10, 0, cyc, res, sawW, rwDone);
    vectors++;
    if (cyc != 33 || res !== 32'h12340) begin
      miscompares++;
      $display("[TB] FAIL flush_then_mul: got busy=%0d res=%h expected 33/12340", cyc, res);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; logic [31:0] res1, res2; bit sawW; logic rwDone;
    do_muldiv(MD_MULHU, 32'h8000_0000, 32'd6, 0, cyc1, res1, sawW, rwDone);
    do_muldiv(MD_DIVU, 32'd81, 32'd9, 0, cyc2, res2, sawW, rwDone);
    vectors++;
    if (cyc1 != 33 || cyc2 != 33 || res1 !== 32'd3 || res2 !== 32'd9) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: got %0d/%0d res %h/%h expected 33/33 3/9",
               cyc1, cyc2, res1, res2);
    end
  endtask

  task automatic test_random_muldiv();
    logic [31:0] specials [4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    logic [2:0]  op; logic [31:0] a, b, exp;
    int cyc; logic [31:0] res; bit sawW; logic rwDone;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      exp = muldiv_model(op, a, b);
      do_muldiv(op, a, b, 1, cyc, res, sawW, rwDone);
      vectors++;
      if (cyc != 33 || sawW || res !== exp) begin
        miscompares++;
        $display("[TB] FAIL rand_muldiv op=%0d a=%h b=%h: got busy=%0d leak=%0d res=%h expected 33/0/%h",
                 op, a, b, cyc, sawW, res, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    issue_muldiv(MD_DIV, 32'hFFFF_0000, 32'd17);
    @(posedge clk); #1;
    clear_d();
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    vectors++;
    if (allOut !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got %h expected 0", allOut);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (BusyE !== 1'b0 || allOut !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_recover: got %h expected 0", allOut);
    end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_branch();
    test_stall_flush();
    test_random_alu();
    test_divu();
    test_div_special();
    test_mul();
    test_flush_muldiv();
    test_back_to_back();
    test_random_muldiv();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
